// File: rtl/mem_access.sv
// mem_access: single-outstanding load/store sequencer between the core and a
// word-wide RAM. Aligns store data into byte lanes, builds byte enables,
// waits (unbounded) for the RAM handshake and extends load data.
module mem_access #(
  parameter int LEN  = 32,
  parameter int BE_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [LEN-1:0]  addr,
  input  logic [LEN-1:0]  wdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [LEN-1:0]  mem_addr,
  output logic [LEN-1:0]  mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_ready,
  input  logic [LEN-1:0]  mem_rdata,
  output logic [LEN-1:0]  rdata,
  output logic            done,
  output logic            busy,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state, state_nxt;
  logic            legal;
  logic [BE_W-1:0] be_in;
  logic [LEN-1:0]  wd_in;
  logic            st_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [LEN-1:0]  lane;
  logic [LEN-1:0]  ld_val;

  // Legality of the incoming request: size/alignment and store-vs-unsigned.
  always_comb begin
    legal = 1'b1;
    case (funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr[0];
      3'b010:  legal = (addr[1:0] == 2'b00);
      3'b100:  legal = ~is_store;
      3'b101:  legal = ~is_store & ~addr[0];
      default: legal = 1'b0;
    endcase
  end

  // Store lane replication and byte enables; loads always read the full word.
  always_comb begin
    be_in = '1;
    wd_in = wdata;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wd_in = {4{wdata[7:0]}};
          be_in = BE_W'(4'b0001) << addr[1:0];
        end
        2'b01: begin
          wd_in = {2{wdata[15:0]}};
          be_in = BE_W'(4'b0011) << addr[1:0];
        end
        default: begin
          wd_in = wdata;
          be_in = '1;
        end
      endcase
    end
  end

  // Next-state logic; start outside IDLE is simply not looked at.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && legal) state_nxt = REQ;
      REQ:     if (mem_ready)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  assign mem_req = (state == REQ);
  assign mem_we  = (state == REQ) & st_q;
  assign done    = (state == DONE);
  assign busy    = (state != IDLE);

  // Capture the request on start in IDLE; held stable through REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (state == IDLE && start) begin
      st_q      <= is_store;
      f3_q      <= funct3;
      off_q     <= addr[1:0];
      mem_addr  <= {addr[LEN-1:2], 2'b00};
      mem_wdata <= wd_in;
      mem_be    <= be_in;
    end
  end

  // One-cycle error pulse for a rejected request; FSM stays in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else        err <= (state == IDLE) && start && !legal;
  end

  // Shift the addressed lane down and extend by access size.
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_val = {{(LEN-8){lane[7]}}, lane[7:0]};
      3'b100:  ld_val = {{(LEN-8){1'b0}}, lane[7:0]};
      3'b001:  ld_val = {{(LEN-16){lane[15]}}, lane[15:0]};
      3'b101:  ld_val = {{(LEN-16){1'b0}}, lane[15:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  // Load result register; only a completing load updates it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               rdata <= '0;
    else if (state == REQ && mem_ready && !st_q) rdata <= ld_val;
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized accesses checked
// against an arithmetic model of the lane/extension rules.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, is_store = 1'b0, mem_ready = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic        mem_req, mem_we, done, busy, err;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [3:0]  mem_be;

  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_rdata = '0;

  mem_access #(.LEN(32), .BE_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rdata(rdata), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic ref_bad(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int off = int'(a % 4);
    case (f3)
      3'd0: return 1'b0;
      3'd1: return (off % 2) != 0;
      3'd2: return off != 0;
      3'd4: return st;
      3'd5: return st || ((off % 2) != 0);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh, b, h;
    sh = rd >> (8 * (a % 4));
    b  = sh % 256;
    h  = sh % 65536;
    case (f3)
      3'd0: return (b > 127) ? b + 32'hFFFFFF00 : b;
      3'd4: return b;
      3'd1: return (h > 32767) ? h + 32'hFFFF0000 : h;
      3'd5: return h;
      default: return rd;
    endcase
  endfunction

  // Drive one access and check every cycle of it. poke re-asserts start
  // (with a different address) during REQ and DONE; it must be ignored.
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int dly, input logic poke);
    logic        bad;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ad;
    bad  = ref_bad(st, f3, a);
    e_ad = a - (a % 4);
    e_be = 4'hF;
    e_wd = wd;
    if (st && f3 == 3'd0) begin e_be = 4'(1 << (a % 4)); e_wd = (wd % 256) * 32'h01010101; end
    if (st && f3 == 3'd1) begin e_be = 4'(3 << (a % 4)); e_wd = (wd % 65536) * 32'h00010001; end

    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    mem_rdata = rd; mem_ready = (dly == 0);
    @(negedge clk);
    start = 1'b0;
    if (bad) begin
      n_chk++;
      if (err !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL err_pulse f3=%0d a=%h: err=%b req=%b busy=%b done=%b, want 1 0 0 0", f3, a, err, mem_req, busy, done);
      end
      @(negedge clk);
      n_chk++;
      if (err !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0 || rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL err_after: err=%b req=%b busy=%b rdata=%h, want 0 0 0 %h", err, mem_req, busy, rdata, exp_rdata);
      end
      mem_ready = 1'b0;
      return;
    end
    for (int c = 0; c <= dly; c++) begin
      mem_ready = (c == dly);
      n_chk++;
      if (mem_req !== 1'b1 || mem_we !== st || mem_addr !== e_ad || mem_be !== e_be ||
          mem_wdata !== e_wd || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL req_cycle%0d st=%b f3=%0d a=%h: req=%b we=%b ad=%h be=%b wd=%h busy=%b done=%b err=%b rd=%h, want 1 %b %h %b %h 1 0 0 %h",
                 c, st, f3, a, mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy, done, err, rdata,
                 st, e_ad, e_be, e_wd, exp_rdata);
      end
      if (poke) begin start = 1'b1; addr = a ^ 32'h40; end
      @(negedge clk);
      start = 1'b0;
    end
    mem_ready = 1'b0;
    if (!st) exp_rdata = ref_load(f3, a, rd);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || err !== 1'b0 || rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL done_cycle st=%b f3=%0d a=%h: done=%b busy=%b req=%b we=%b err=%b rdata=%h, want 1 1 0 0 0 %h",
               st, f3, a, done, busy, mem_req, mem_we, err, rdata, exp_rdata);
    end
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL back_idle: done=%b busy=%b req=%b rdata=%h, want 0 0 0 %h", done, busy, mem_req, rdata, exp_rdata);
    end
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if (mem_req !== 0 || mem_we !== 0 || done !== 0 || busy !== 0 || err !== 0 ||
        rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0 || mem_be !== 0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b we=%b done=%b busy=%b err=%b rdata=%h ad=%h wd=%h be=%b, want all 0",
               mem_req, mem_we, done, busy, err, rdata, mem_addr, mem_wdata, mem_be);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    run_access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    n_chk++;
    if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_100: rdata=%h want deadbeef", rdata); end
    run_access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80112233, 0, 1'b0);
    n_chk++;
    if (rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_103: rdata=%h want ffffff80", rdata); end
    run_access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233, 1, 1'b0);
    n_chk++;
    if (rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu_103: rdata=%h want 00000080", rdata); end
    run_access(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 3, 1'b0);
    n_chk++;
    if (rdata !== 32'h00000080) begin n_fail++; $display("FAIL sh_keeps_rdata: rdata=%h want 00000080", rdata); end
    run_access(1'b0, 3'd2, 32'h101, 32'h0, 32'h55555555, 0, 1'b0);
    run_access(1'b1, 3'd4, 32'h104, 32'h0, 32'h0, 0, 1'b0);
    run_access(1'b0, 3'd7, 32'h104, 32'h0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 3'd1, 32'h3FE, 32'h0, 32'h9ABC1234, 2, 1'b1);
    run_access(1'b1, 3'd0, 32'h3FD, 32'hA5, 32'h0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h300; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req: req=%b want 1", mem_req); end
    #2 reset = 1'b0;
    #1;
    exp_rdata = '0;
    n_chk++;
    if (mem_req !== 0 || busy !== 0 || done !== 0 || rdata !== 0 || mem_be !== 0) begin
      n_fail++;
      $display("FAIL async_abort: req=%b busy=%b done=%b rdata=%h be=%b, want 0", mem_req, busy, done, rdata, mem_be);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (done !== 0 || mem_req !== 0) begin n_fail++; $display("FAIL held_reset%0d: done=%b req=%b want 0", i, done, mem_req); end
    end
    reset = 1'b1;
    mem_ready = 1'b0;
    run_access(1'b0, 3'd2, 32'h0, 32'h0, 32'h13579BDF, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
